// File: rtl/result_check.sv
// Result checker: pops one expected record and one captured DUT vector, compares them under the
// bitmask and don't-care bits, and writes a two-word result record. Option macro: CHECK_STOP_ON_FAIL_EN.
module result_check #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = 2,
    parameter int STF_WIDTH  = 24,
    parameter int RTF_WIDTH  = 24,
    parameter int CHF_WIDTH  = 68,
    parameter int SCC_WIDTH  = 5,
    parameter int SCD_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE = 20'h80000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [CHF_WIDTH-1:0]  cfifo_q,
    output logic                  cfifo_rdreq,
    input  logic                  cfifo_rdempty,
    input  logic [RTF_WIDTH-1:0]  rfifo_q,
    output logic                  rfifo_rdreq,
    input  logic                  rfifo_rdempty,
    input  logic [SCC_WIDTH-1:0]  sc_cmd,
    input  logic [SCD_WIDTH-1:0]  sc_data,
    output logic                  sc_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    output logic [CNT_WIDTH-1:0]  pass_count,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  halted,
    output logic                  done
);

    // state   | meaning
    // IDLE    | waiting for both FIFOs non-empty; pops both heads on entry to COMPARE
    // COMPARE | evaluate mismatch, bump counters, stage word 0
    // WR0     | result word 0 on the bus until accepted
    // WR1     | result word 1 on the bus until accepted, then advance record index
    // WRH0    | failing rec_addr high word at RES_BASE-2 (stop-on-fail build)
    // WRH1    | failing rec_addr low word at RES_BASE-1 (stop-on-fail build)
    // HALT    | stopped on failure until clear (stop-on-fail build)
    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WR0,
        WR1
`ifdef CHECK_STOP_ON_FAIL_EN
        , WRH0,
        WRH1,
        HALT
`endif
    } state_t;

    state_t                state;
    logic [RTF_WIDTH-1:0]  act_r;
    logic [RTF_WIDTH-1:0]  dc_r;
    logic [STF_WIDTH-1:0]  exp_r;
    logic [STF_WIDTH-1:0]  bitmask;
    logic [ADDR_WIDTH-1:0] rec_r;
    logic [ADDR_WIDTH-2:0] idx;
    logic                  fail_r;
    logic                  skip_inc;
    logic                  pop;
    logic                  mism_any;

    assign pop            = (state == IDLE) && !cfifo_rdempty && !rfifo_rdempty;
    assign cfifo_rdreq    = pop;
    assign rfifo_rdreq    = pop;
    assign sc_ready       = (state == IDLE);
    assign done           = (state == IDLE) && cfifo_rdempty && rfifo_rdempty;
    assign mem_byteenable = '1;
    assign mism_any       = |((act_r ^ exp_r) & bitmask & ~dc_r);

`ifdef CHECK_STOP_ON_FAIL_EN
    logic        halted_r;
    logic [23:0] rec_word;
    assign rec_word = {4'b0, rec_r};
    assign halted   = halted_r;
`else
    logic unused_rec;
    assign unused_rec = ^rec_r;
    assign halted     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bitmask       <= '1;
            act_r         <= '0;
            dc_r          <= '0;
            exp_r         <= '0;
            rec_r         <= '0;
            idx           <= '0;
            fail_r        <= 1'b0;
            skip_inc      <= 1'b0;
            pass_count    <= '0;
            fail_count    <= '0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
`ifdef CHECK_STOP_ON_FAIL_EN
            halted_r      <= 1'b0;
`endif
        end else begin
            if (sc_cmd == SCC_WIDTH'(1))
                bitmask <= sc_data[STF_WIDTH-1:0];

            case (state)
                IDLE: begin
                    skip_inc <= 1'b0;
                    if (pop) begin
                        {dc_r, exp_r, rec_r} <= cfifo_q;
                        act_r                <= rfifo_q;
                        state                <= COMPARE;
                    end
                end
                COMPARE: begin
                    fail_r <= mism_any;
                    if (mism_any) begin
                        if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
                    end else begin
                        if (pass_count != '1) pass_count <= pass_count + CNT_WIDTH'(1);
                    end
                    mem_address   <= RES_BASE + {idx, 1'b0};
                    mem_writedata <= act_r[23:8];
                    mem_write     <= 1'b1;
                    state         <= WR0;
                end
                WR0: begin
                    if (!mem_waitrequest) begin
                        mem_address   <= mem_address + ADDR_WIDTH'(1);
                        mem_writedata <= {act_r[7:0], 7'b0, fail_r};
                        state         <= WR1;
                    end
                end
                WR1: begin
                    if (!mem_waitrequest) begin
                        // a clear seen during this write already reset idx; keep it at 0
                        if (!clear && !skip_inc) idx <= idx + (ADDR_WIDTH-1)'(1);
`ifdef CHECK_STOP_ON_FAIL_EN
                        if (fail_r) begin
                            mem_address   <= RES_BASE - ADDR_WIDTH'(2);
                            mem_writedata <= rec_word[23:8];
                            state         <= WRH0;
                        end else begin
                            mem_write <= 1'b0;
                            state     <= IDLE;
                        end
`else
                        mem_write <= 1'b0;
                        state     <= IDLE;
`endif
                    end
                end
`ifdef CHECK_STOP_ON_FAIL_EN
                WRH0: begin
                    if (!mem_waitrequest) begin
                        mem_address   <= mem_address + ADDR_WIDTH'(1);
                        mem_writedata <= {rec_word[7:0], 8'b0};
                        state         <= WRH1;
                    end
                end
                WRH1: begin
                    if (!mem_waitrequest) begin
                        mem_write <= 1'b0;
                        halted_r  <= 1'b1;
                        state     <= HALT;
                    end
                end
                HALT: begin
                    if (clear) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase

            if (clear) begin
                pass_count <= '0;
                fail_count <= '0;
                idx        <= '0;
`ifdef CHECK_STOP_ON_FAIL_EN
                halted_r   <= 1'b0;
`endif
                if (state != IDLE) skip_inc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_check.sv
// Scoreboard bench for result_check: queue-modelled FIFOs, expected write records pushed with
// stimulus and compared against accepted Avalon writes.
module tb_result_check;

    logic        clock = 1'b0;
    logic        reset_n, clear;
    logic [67:0] cfifo_q;
    logic        cfifo_rdreq, cfifo_rdempty;
    logic [23:0] rfifo_q;
    logic        rfifo_rdreq, rfifo_rdempty;
    logic [4:0]  sc_cmd;
    logic [23:0] sc_data;
    logic        sc_ready;
    logic [19:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic        mem_waitrequest;
    logic [15:0] pass_count, fail_count;
    logic        halted, done;

    logic        sat_rst_n;
    logic [3:0]  sat_pass, sat_fail;
    logic        sat_unused_crd, sat_unused_rrd, sat_unused_rdy, sat_unused_wr;
    logic        sat_unused_halt, sat_unused_done;
    logic [19:0] sat_unused_addr;
    logic [1:0]  sat_unused_be;
    logic [15:0] sat_unused_wd;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] mask_m;
    logic [18:0] idx_m;
    logic [15:0] pass_m, fail_m;
    logic [67:0] cq[$];
    logic [23:0] rq[$];
    logic [35:0] exp_w[$];
    logic [35:0] obs_w[$];

    always #5 clock = ~clock;

    result_check dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .cfifo_q(cfifo_q), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
        .rfifo_q(rfifo_q), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
        .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
        .pass_count(pass_count), .fail_count(fail_count), .halted(halted), .done(done)
    );

    // narrow-counter instance fed a permanently failing stream, to reach saturation quickly
    result_check #(.CNT_WIDTH(4)) u_sat (
        .clock(clock), .reset_n(sat_rst_n), .clear(1'b0),
        .cfifo_q({24'h000000, 24'hFFFFFF, 20'h00000}), .cfifo_rdreq(sat_unused_crd),
        .cfifo_rdempty(1'b0), .rfifo_q(24'h000000), .rfifo_rdreq(sat_unused_rrd),
        .rfifo_rdempty(1'b0), .sc_cmd(5'd0), .sc_data(24'h000000), .sc_ready(sat_unused_rdy),
        .mem_address(sat_unused_addr), .mem_byteenable(sat_unused_be), .mem_write(sat_unused_wr),
        .mem_writedata(sat_unused_wd), .mem_waitrequest(1'b0),
        .pass_count(sat_pass), .fail_count(sat_fail), .halted(sat_unused_halt),
        .done(sat_unused_done)
    );

    function automatic void refresh();
        cfifo_rdempty = (cq.size() == 0);
        rfifo_rdempty = (rq.size() == 0);
        cfifo_q       = (cq.size() == 0) ? 68'h0 : cq[0];
        rfifo_q       = (rq.size() == 0) ? 24'h0 : rq[0];
    endfunction

    always @(posedge clock) begin
        logic pc, pr;
        pc = cfifo_rdreq;
        pr = rfifo_rdreq;
        #1;
        if (pc && cq.size() > 0) void'(cq.pop_front());
        if (pr && rq.size() > 0) void'(rq.pop_front());
        refresh();
    end

    always @(negedge clock) begin
        #2;
        if (reset_n && mem_write && !mem_waitrequest)
            obs_w.push_back({mem_address, mem_writedata});
    end

    task automatic model_vec(input logic [23:0] dc, input logic [23:0] e, input logic [23:0] a);
        logic f;
        f = |((a ^ e) & mask_m & ~dc);
        exp_w.push_back({20'h80000 + {idx_m, 1'b0}, a[23:8]});
        exp_w.push_back({20'h80001 + {idx_m, 1'b0}, a[7:0], 7'b0, f});
        idx_m = idx_m + 19'd1;
        if (f) fail_m = fail_m + 16'd1;
        else   pass_m = pass_m + 16'd1;
    endtask

    task automatic push_vec(input logic [23:0] dc, input logic [23:0] e, input logic [23:0] a);
        model_vec(dc, e, a);
        cq.push_back({dc, e, 20'h0ABCD});
        rq.push_back(a);
        refresh();
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            #3;
            if (done && cq.size() == 0 && rq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (mem_write !== 1'b0 || mem_address !== 20'h0 || mem_writedata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem got wr=%b addr=%h data=%h want 0/0/0", mem_write, mem_address, mem_writedata);
        end
        checks++;
        if (pass_count !== 16'h0 || fail_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_counts got %h/%h want 0/0", pass_count, fail_count);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (cfifo_rdreq !== 1'b0 || rfifo_rdreq !== 1'b0 || done !== 1'b1 || sc_ready !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rd=%b%b done=%b rdy=%b halt=%b want 00 1 1 0",
                     cfifo_rdreq, rfifo_rdreq, done, sc_ready, halted);
        end
        checks++;
        if (mem_byteenable !== 2'b11) begin
            errors++;
            $display("FAIL byteenable got %b want 11", mem_byteenable);
        end
    endtask

    task automatic test_compare();
        bit ok;
        push_vec(24'h000000, 24'hA5A5A5, 24'hA5A5A5);
        push_vec(24'h000001, 24'hA5A5A5, 24'hA5A5A4);
        push_vec(24'h000000, 24'hA5A5A5, 24'hA5A5A4);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL compare_drain got busy want idle"); end
        checks++;
        if (obs_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL compare_wcount got %0d want %0d", obs_w.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < obs_w.size()) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL compare_write%0d got %h want %h", i, obs_w[i], exp_w[i]);
            end
        end
        exp_w.delete(); obs_w.delete();
        checks++;
        if (pass_count !== pass_m || fail_count !== fail_m) begin
            errors++;
            $display("FAIL compare_counts got %h/%h want %h/%h", pass_count, fail_count, pass_m, fail_m);
        end
    endtask

    task automatic test_bitmask();
        bit ok;
        @(negedge clock); sc_cmd = 5'd1; sc_data = 24'hFFFF00; mask_m = 24'hFFFF00;
        @(negedge clock); sc_cmd = 5'd0;
        push_vec(24'h000000, 24'hA5A5A5, 24'hA5A55A);
        drain(ok);
        @(negedge clock); sc_cmd = 5'd1; sc_data = 24'hFFFFFF; mask_m = 24'hFFFFFF;
        @(negedge clock); sc_cmd = 5'd2; sc_data = 24'h000000;
        @(negedge clock); sc_cmd = 5'd0;
        push_vec(24'h000000, 24'h3C3C3C, 24'h3C3C3D);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bitmask_drain got busy want idle"); end
        checks++;
        if (obs_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL bitmask_wcount got %0d want %0d", obs_w.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < obs_w.size()) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL bitmask_write%0d got %h want %h", i, obs_w[i], exp_w[i]);
            end
        end
        exp_w.delete(); obs_w.delete();
        checks++;
        if (pass_count !== pass_m || fail_count !== fail_m) begin
            errors++;
            $display("FAIL bitmask_counts got %h/%h want %h/%h", pass_count, fail_count, pass_m, fail_m);
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [19:0] a0;
        a0 = 20'h80000 + {idx_m, 1'b0};
        mem_waitrequest = 1'b1;
        push_vec(24'h000000, 24'h123456, 24'h123456);
        push_vec(24'h000000, 24'h0F0F0F, 24'h0F0F0E);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_write === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_start got no strobe want strobe"); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clock);
            if (i == 5) mem_waitrequest = 1'b0;
            checks++;
            if (mem_write !== 1'b1 || mem_address !== a0 || mem_writedata !== 16'h1234 || cfifo_rdreq !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got wr=%b addr=%h data=%h rd=%b want 1 %h 1234 0",
                         i, mem_write, mem_address, mem_writedata, cfifo_rdreq, a0);
            end
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_drain got busy want idle"); end
        checks++;
        if (obs_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL stall_wcount got %0d want %0d", obs_w.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < obs_w.size()) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL stall_write%0d got %h want %h", i, obs_w[i], exp_w[i]);
            end
        end
        exp_w.delete(); obs_w.delete();
    endtask

    task automatic test_starve();
        bit ok;
        cq.push_back({24'h000000, 24'h00FF00, 20'h00001});
        refresh();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (cfifo_rdreq !== 1'b0 || rfifo_rdreq !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL starve_wait%0d got rd=%b%b done=%b want 00 0", i, cfifo_rdreq, rfifo_rdreq, done);
            end
        end
        @(negedge clock);
        rq.push_back(24'h00FF00);
        refresh();
        model_vec(24'h000000, 24'h00FF00, 24'h00FF00);
        #1;
        checks++;
        if (cfifo_rdreq !== 1'b1 || rfifo_rdreq !== 1'b1) begin
            errors++;
            $display("FAIL starve_pop got rd=%b%b want 11", cfifo_rdreq, rfifo_rdreq);
        end
        drain(ok);
        checks++;
        if (obs_w.size() != exp_w.size() || !ok) begin
            errors++;
            $display("FAIL starve_wcount got %0d want %0d", obs_w.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < obs_w.size()) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL starve_write%0d got %h want %h", i, obs_w[i], exp_w[i]);
            end
        end
        exp_w.delete(); obs_w.delete();
    endtask

    task automatic test_clear();
        bit ok;
        @(negedge clock); clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        idx_m = '0; pass_m = '0; fail_m = '0;
        checks++;
        if (pass_count !== 16'h0 || fail_count !== 16'h0) begin
            errors++;
            $display("FAIL clear_idle got %h/%h want 0/0", pass_count, fail_count);
        end
        push_vec(24'h000000, 24'h111111, 24'h111110);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_write === 1'b1) begin ok = 1'b1; break; end
        end
        clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        idx_m = '0; pass_m = '0; fail_m = '0;
        push_vec(24'h000000, 24'h222222, 24'h222222);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clear_drain got busy want idle"); end
        checks++;
        if (obs_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL clear_wcount got %0d want %0d", obs_w.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < obs_w.size()) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL clear_write%0d got %h want %h", i, obs_w[i], exp_w[i]);
            end
        end
        exp_w.delete(); obs_w.delete();
        checks++;
        if (pass_count !== pass_m || fail_count !== fail_m) begin
            errors++;
            $display("FAIL clear_counts got %h/%h want %h/%h", pass_count, fail_count, pass_m, fail_m);
        end
    endtask

    task automatic test_reset_mid_wr1();
        bit ok;
        @(negedge clock); sc_cmd = 5'd1; sc_data = 24'h000000;
        @(negedge clock); sc_cmd = 5'd0;
        cq.push_back({24'h000000, 24'h0000FF, 20'h00002});
        rq.push_back(24'h000000);
        refresh();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_write === 1'b1 && mem_address[0] === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL midwr1_reach got no WR1 want WR1"); end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_address !== 20'h0 || mem_writedata !== 16'h0 ||
            pass_count !== 16'h0 || fail_count !== 16'h0 || done !== 1'b1) begin
            errors++;
            $display("FAIL midwr1_reset got wr=%b addr=%h data=%h cnt=%h/%h done=%b want 0 0 0 0/0 1",
                     mem_write, mem_address, mem_writedata, pass_count, fail_count, done);
        end
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock); #3;
        exp_w.delete(); obs_w.delete();
        idx_m = '0; pass_m = '0; fail_m = '0; mask_m = 24'hFFFFFF;
        push_vec(24'h000000, 24'h000000, 24'h000001);
        drain(ok);
        checks++;
        if (obs_w.size() != exp_w.size() || !ok) begin
            errors++;
            $display("FAIL midwr1_wcount got %0d want %0d", obs_w.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < obs_w.size()) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL midwr1_write%0d got %h want %h", i, obs_w[i], exp_w[i]);
            end
        end
        exp_w.delete(); obs_w.delete();
        checks++;
        if (fail_count !== fail_m || pass_count !== pass_m) begin
            errors++;
            $display("FAIL midwr1_mask got %h/%h want %h/%h", pass_count, fail_count, pass_m, fail_m);
        end
    endtask

    task automatic test_saturate();
        @(negedge clock);
        checks++;
        if (sat_fail !== 4'h0) begin
            errors++;
            $display("FAIL sat_reset got %h want 0", sat_fail);
        end
        sat_rst_n = 1'b1;
        repeat (120) @(negedge clock);
        checks++;
        if (sat_fail !== 4'hF || sat_pass !== 4'h0) begin
            errors++;
            $display("FAIL sat_hold got %h/%h want f/0", sat_fail, sat_pass);
        end
    endtask

    initial begin
        reset_n = 1'b0; sat_rst_n = 1'b0; clear = 1'b0;
        sc_cmd = 5'd0; sc_data = 24'h0; mem_waitrequest = 1'b0;
        mask_m = 24'hFFFFFF; idx_m = '0; pass_m = '0; fail_m = '0;
        refresh();
        test_reset();
        test_compare();
        test_bitmask();
        test_stall();
        test_starve();
        test_clear();
        test_reset_mid_wr1();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
